// File: rtl/ex_hazard_scoreboard_if.sv
// Pipeline-control view of the EX hazard scoreboard: ID/EX/MEM/WB register tags in, bypass selects and stall out.
interface ex_hazard_scoreboard_if #(
    parameter int AW   = 5,
    parameter int NSRC = 2
);
    logic [NSRC*AW-1:0] id_src_addr;
    logic [AW-1:0]      id_rd;
    logic               id_regwrite;
    logic               id_md;
    logic [NSRC*AW-1:0] ex_src_addr;
    logic [AW-1:0]      ex_rd;
    logic               ex_memread;
    logic [AW-1:0]      mem_rd;
    logic               mem_regwrite;
    logic [AW-1:0]      wb_rd;
    logic               wb_regwrite;
    logic               md_start;
    logic [AW-1:0]      md_rd;
    logic [2*NSRC-1:0]  ex_fwd_sel;
    logic               stall;
    logic               md_busy;
    logic               md_done;
    logic [AW-1:0]      md_done_rd;

    modport master (
        output id_src_addr, id_rd, id_regwrite, id_md,
        output ex_src_addr, ex_rd, ex_memread,
        output mem_rd, mem_regwrite, wb_rd, wb_regwrite,
        output md_start, md_rd,
        input  ex_fwd_sel, stall, md_busy, md_done, md_done_rd
    );

    modport slave (
        input  id_src_addr, id_rd, id_regwrite, id_md,
        input  ex_src_addr, ex_rd, ex_memread,
        input  mem_rd, mem_regwrite, wb_rd, wb_regwrite,
        input  md_start, md_rd,
        output ex_fwd_sel, stall, md_busy, md_done, md_done_rd
    );
endinterface

// File: rtl/ex_hazard_scoreboard.sv
// EX bypass select, load-use detect and single-slot mul/div countdown scoreboard.
// Bypass/stall are combinational; md_done fires MD_LAT cycles after issue; stall is the only backpressure.
module ex_hazard_scoreboard #(
    parameter int AW     = 5,
    parameter int NSRC   = 2,
    parameter int MD_LAT = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    ex_hazard_scoreboard_if.slave hz
);

    localparam int CW = $clog2(MD_LAT);
    localparam logic [CW-1:0] CNT_LOAD = CW'(MD_LAT - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [AW-1:0]     pend_rd;

    logic              busy;
    logic              done;
    logic              pend_live;
    logic              load_use;
    logic              raw_hit;
    logic              waw_hit;
    logic              struct_hit;
    logic [2*NSRC-1:0] fwd_sel;

    // ---------------------------------------------------------------
    // Scoreboard: the done cycle may accept a fresh issue (back-to-back);
    // an issue while the count is still running is ignored.
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            cnt     <= '0;
            pend_rd <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (hz.md_start) begin
                        cnt     <= CNT_LOAD;
                        pend_rd <= hz.md_rd;
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (hz.md_start) begin
                        cnt     <= CNT_LOAD;
                        pend_rd <= hz.md_rd;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy      = (state == BUSY);
    assign done      = busy && (cnt == '0);
    assign pend_live = busy && (pend_rd != '0);

    // ---------------------------------------------------------------
    // Per-operand bypass and hazard compares
    // ---------------------------------------------------------------
    always_comb begin
        fwd_sel  = '0;
        load_use = 1'b0;
        raw_hit  = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            if (hz.mem_regwrite && (hz.mem_rd != '0) &&
                (hz.ex_src_addr[i*AW +: AW] == hz.mem_rd)) begin
                fwd_sel[2*i +: 2] = 2'b10;
            end else if (hz.wb_regwrite && (hz.wb_rd != '0) &&
                         (hz.ex_src_addr[i*AW +: AW] == hz.wb_rd)) begin
                fwd_sel[2*i +: 2] = 2'b01;
            end

            if (hz.ex_memread && (hz.ex_rd != '0) &&
                (hz.id_src_addr[i*AW +: AW] == hz.ex_rd)) begin
                load_use = 1'b1;
            end

            // Consumer reads the register file after writeback, so RAW holds through done
            if (pend_live && (hz.id_src_addr[i*AW +: AW] == pend_rd)) begin
                raw_hit = 1'b1;
            end
        end
    end

    assign waw_hit    = pend_live && hz.id_regwrite && (hz.id_rd == pend_rd);
    assign struct_hit = busy && hz.id_md && (cnt != '0);

    assign hz.ex_fwd_sel = fwd_sel;
    assign hz.stall      = load_use || raw_hit || waw_hit || struct_hit;
    assign hz.md_busy    = busy;
    assign hz.md_done    = done;
    assign hz.md_done_rd = done ? pend_rd : '0;

endmodule
